rtc_timekeeper: RTL

Parametrised hours/minutes/seconds timekeeper with an integrated clock prescaler, run enable, synchronous time-load port and optional minute-resolution alarm. It extends the team's plain sec/min counter into a full day counter that runs from the system clock rather than a 1 Hz clock. It drives display, scheduling and wake-up logic.

---
 rtl/rtc_timekeeper.sv | 85 ++++++++
 1 files changed

// File: rtl/rtc_timekeeper.sv
// rtc_timekeeper: hh:mm:ss day counter with clk prescaler, time load and optional alarm (RTC_ALARM_EN)
module rtc_timekeeper #(
  parameter int CLK_DIV = 1,
  parameter int HOURS_PER_DAY = 24
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       load,
  input  logic [5:0] load_sec,
  input  logic [5:0] load_min,
  input  logic [5:0] load_hour,
  input  logic       alarm_en,
  input  logic [5:0] alarm_min,
  input  logic [5:0] alarm_hour,
  output logic [5:0] sec,
  output logic [5:0] min,
  output logic [5:0] hour,
  output logic       sec_tick,
  output logic       day_wrap,
  output logic       load_err,
  output logic       alarm_hit
);
  localparam int DW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_MAX = DW'(CLK_DIV - 1);
  localparam logic [5:0] HOUR_MAX = 6'(HOURS_PER_DAY - 1);
  logic [DW-1:0] div_cnt;
  logic adv, valid, s_end, m_end, h_end, hit;
  logic [5:0] nsec, nmin, nhour;
  // advance detect, load validity and the next time after one advance
  always_comb begin
    adv = en && div_cnt == DIV_MAX;
    valid = load_sec < 6'd60 && load_min < 6'd60 && load_hour <= HOUR_MAX;
    s_end = sec == 6'd59;
    m_end = min == 6'd59;
    h_end = hour == HOUR_MAX;
    nsec = s_end ? 6'd0 : sec + 6'd1;
    nmin = !s_end ? min : m_end ? 6'd0 : min + 6'd1;
    nhour = !(s_end && m_end) ? hour : h_end ? 6'd0 : hour + 6'd1;
  end
`ifdef RTC_ALARM_EN
  assign hit = alarm_en && s_end && nmin == alarm_min && nhour == alarm_hour;
`else
  logic unused_alarm;
  assign unused_alarm = ^{alarm_en, alarm_min, alarm_hour};
  assign hit = 1'b0;
`endif
  // load wins over a coincident advance; an invalid load also blocks that advance
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt <= '0;
      sec <= '0;
      min <= '0;
      hour <= '0;
      sec_tick <= 1'b0;
      day_wrap <= 1'b0;
      load_err <= 1'b0;
      alarm_hit <= 1'b0;
    end else begin
      sec_tick <= 1'b0;
      day_wrap <= 1'b0;
      load_err <= 1'b0;
      alarm_hit <= 1'b0;
      if (load) begin
        load_err <= !valid;
        if (valid) begin
          sec <= load_sec;
          min <= load_min;
          hour <= load_hour;
          div_cnt <= '0;
        end
      end else if (en) begin
        div_cnt <= adv ? '0 : div_cnt + DW'(1);
        if (adv) begin
          sec <= nsec;
          min <= nmin;
          hour <= nhour;
          sec_tick <= 1'b1;
          day_wrap <= s_end && m_end && h_end;
          alarm_hit <= hit;
        end
      end
    end
  end
endmodule
